// File: rtl/emulador_teclado_pkg.sv
// rtl/emulador_teclado_pkg.sv - shared key-matrix codes and emulator state encoding
package emulador_teclado_pkg;

  localparam logic [3:0] COL_1  = 4'b0001;
  localparam logic [3:0] COL_2  = 4'b0010;
  localparam logic [3:0] COL_3  = 4'b0100;
  localparam logic [3:0] COL_4  = 4'b1000;
  localparam logic [3:0] FILA_1 = 4'b0001;
  localparam logic [3:0] FILA_2 = 4'b0010;
  localparam logic [3:0] FILA_3 = 4'b0100;
  localparam logic [3:0] FILA_4 = 4'b1000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REBOTE = 2'd1;
  localparam logic [1:0] ST_FIRME  = 2'd2;
  localparam logic [1:0] ST_SUELTA = 2'd3;

  typedef struct packed {
    logic [1:0] fila;
    logic [1:0] col;
  } tecla_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/emulador_teclado_if.sv
// rtl/emulador_teclado_if.sv - scan/command bundle between keypad driver and emulator
interface emulador_teclado_if;
  logic [3:0] col;
  logic [3:0] fila;
  logic [3:0] tecla;
  logic       inicio;
  logic       ocupado;
  logic       contacto;
  logic       fin;

  modport master (output col, tecla, inicio, input fila, ocupado, contacto, fin);
  modport slave  (input col, tecla, inicio, output fila, ocupado, contacto, fin);
endinterface

// File: rtl/emulador_teclado_mapa_tecla.sv
// rtl/emulador_teclado_mapa_tecla.sv - row/column index pair to one-hot line codes
module mapa_tecla
  import emulador_teclado_pkg::*;
#(
  parameter logic [3:0] col_1  = COL_1,
  parameter logic [3:0] col_2  = COL_2,
  parameter logic [3:0] col_3  = COL_3,
  parameter logic [3:0] col_4  = COL_4,
  parameter logic [3:0] fila_1 = FILA_1,
  parameter logic [3:0] fila_2 = FILA_2,
  parameter logic [3:0] fila_3 = FILA_3,
  parameter logic [3:0] fila_4 = FILA_4
) (
  input  tecla_t     tecla_i,
  output logic [3:0] col_c_o,
  output logic [3:0] fila_r_o
);

  always_comb begin
    col_c_o = col_1;
    case (tecla_i.col)
      2'd0: col_c_o = col_1;
      2'd1: col_c_o = col_2;
      2'd2: col_c_o = col_3;
      2'd3: col_c_o = col_4;
      default: col_c_o = col_1;
    endcase
  end

  always_comb begin
    fila_r_o = fila_1;
    case (tecla_i.fila)
      2'd0: fila_r_o = fila_1;
      2'd1: fila_r_o = fila_2;
      2'd2: fila_r_o = fila_3;
      2'd3: fila_r_o = fila_4;
      default: fila_r_o = fila_1;
    endcase
  end

endmodule

// File: rtl/emulador_teclado.sv
// rtl/emulador_teclado.sv - passive matrix-keypad emulator: bounce, hold, release per command
module emulador_teclado
  import emulador_teclado_pkg::*;
#(
  parameter logic [3:0] col_1  = COL_1,
  parameter logic [3:0] col_2  = COL_2,
  parameter logic [3:0] col_3  = COL_3,
  parameter logic [3:0] col_4  = COL_4,
  parameter logic [3:0] fila_1 = FILA_1,
  parameter logic [3:0] fila_2 = FILA_2,
  parameter logic [3:0] fila_3 = FILA_3,
  parameter logic [3:0] fila_4 = FILA_4,
  parameter int REBOTE_CICLOS = 4,
  parameter int HOLD_CICLOS   = 8,
  parameter int GAP_CICLOS    = 4
) (
  input  logic                clk,
  input  logic                rst,
  emulador_teclado_if.slave   bus
);

  localparam int CW = $clog2(max3(REBOTE_CICLOS, HOLD_CICLOS, GAP_CICLOS)) + 1;
  localparam logic [CW-1:0] CNT_REBOTE = CW'(REBOTE_CICLOS);
  localparam logic [CW-1:0] CNT_HOLD   = CW'(HOLD_CICLOS);
  localparam logic [CW-1:0] CNT_GAP    = CW'(GAP_CICLOS);
  localparam logic [CW-1:0] CNT_UNO    = CW'(1);

  logic [1:0]    estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          contacto_q, contacto_d;
  logic          fin_q, fin_d;
  tecla_t        tecla_q, tecla_d;
  logic [3:0]    col_c, fila_r;

  mapa_tecla #(
    .col_1(col_1), .col_2(col_2), .col_3(col_3), .col_4(col_4),
    .fila_1(fila_1), .fila_2(fila_2), .fila_3(fila_3), .fila_4(fila_4)
  ) u_mapa (
    .tecla_i  (tecla_q),
    .col_c_o  (col_c),
    .fila_r_o (fila_r)
  );

  // Each phase counter is loaded with the phase length and the phase ends on the cycle it reads 1.
  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    contacto_d = contacto_q;
    fin_d      = 1'b0;
    tecla_d    = tecla_q;
    case (estado_q)
      ST_IDLE: begin
        if (bus.inicio) begin
          tecla_d    = tecla_t'(bus.tecla);
          contacto_d = 1'b1;
          if (REBOTE_CICLOS == 0) begin
            estado_d = ST_FIRME;
            cnt_d    = CNT_HOLD;
          end else begin
            estado_d = ST_REBOTE;
            cnt_d    = CNT_REBOTE;
          end
        end
      end
      ST_REBOTE: begin
        if (cnt_q == CNT_UNO) begin
          estado_d   = ST_FIRME;
          cnt_d      = CNT_HOLD;
          contacto_d = 1'b1;
        end else begin
          cnt_d      = cnt_q - CNT_UNO;
          contacto_d = ~contacto_q;
        end
      end
      ST_FIRME: begin
        if (cnt_q == CNT_UNO) begin
          estado_d   = ST_SUELTA;
          cnt_d      = CNT_GAP;
          contacto_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_UNO;
        end
      end
      ST_SUELTA: begin
        if (cnt_q == CNT_UNO) begin
          estado_d = ST_IDLE;
          cnt_d    = '0;
          fin_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_UNO;
        end
      end
      default: estado_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= ST_IDLE;
      cnt_q      <= '0;
      contacto_q <= 1'b0;
      fin_q      <= 1'b0;
      tecla_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      contacto_q <= contacto_d;
      fin_q      <= fin_d;
      tecla_q    <= tecla_d;
    end
  end

  // Rows answer the column scan with no register, like a real contact matrix.
  assign bus.fila     = (contacto_q && ((bus.col & col_c) != 4'b0000)) ? fila_r : 4'b0000;
  assign bus.ocupado  = (estado_q != ST_IDLE);
  assign bus.contacto = contacto_q;
  assign bus.fin      = fin_q;

endmodule

// File: tb/tb_emulador_teclado.sv
// tb/tb_emulador_teclado.sv - self-checking bench for emulador_teclado
module tb_emulador_teclado;

  localparam int R0 = 4;
  localparam int R1 = 0;
  localparam int H  = 8;
  localparam int G  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  emulador_teclado_if bus0 ();
  emulador_teclado_if bus1 ();

  emulador_teclado dut0 (.clk(clk), .rst(rst), .bus(bus0));
  emulador_teclado #(.REBOTE_CICLOS(R1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  // Reference model: busy-cycle index since acceptance (0 = idle), latched key, expected fin.
  int         ph    [2];
  logic [3:0] key   [2];
  logic       fin_e [2];

  function automatic int rebote(input int i);
    return (i == 0) ? R0 : R1;
  endfunction

  function automatic logic exp_contacto(input int i);
    int p;
    int r;
    p = ph[i];
    r = rebote(i);
    if (p == 0) return 1'b0;
    if (p <= r) return (p % 2) == 1;
    if (p <= r + H) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_fila(input int i, input logic [3:0] c);
    logic [3:0] k;
    k = key[i];
    if (exp_contacto(i) && c[k[1:0]]) return 4'b0001 << k[3:2];
    return 4'b0000;
  endfunction

  task automatic model_step(input int i, input logic ini, input logic [3:0] t);
    if (rst) begin
      ph[i] = 0; fin_e[i] = 1'b0; key[i] = 4'b0000;
    end else if (ph[i] == 0) begin
      fin_e[i] = 1'b0;
      if (ini) begin
        key[i] = t;
        ph[i] = 1;
      end
    end else begin
      fin_e[i] = 1'b0;
      if (ph[i] == rebote(i) + H + G) begin
        ph[i] = 0;
        fin_e[i] = 1'b1;
      end else begin
        ph[i] = ph[i] + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, bus0.inicio, bus0.tecla);
    model_step(1, bus1.inicio, bus1.tecla);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.inicio = 1'b1; bus1.inicio = 1'b1;
    bus0.tecla = 4'($urandom_range(0, 15)); bus1.tecla = 4'($urandom_range(0, 15));
    bus0.col = 4'b1111; bus1.col = 4'b1111;
    tick();
    tick();
    checks++;
    if (bus0.ocupado !== 1'b0 || bus1.ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_inicio ocupado got %b/%b exp 0/0", bus0.ocupado, bus1.ocupado);
    end
    rst = 1'b0;
    bus0.inicio = 1'b0; bus1.inicio = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (bus0.fila !== 4'b0000 || bus0.ocupado !== 1'b0 || bus0.contacto !== 1'b0 || bus0.fin !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle0 fila %b ocupado %b contacto %b fin %b exp 0000 0 0 0",
                 bus0.fila, bus0.ocupado, bus0.contacto, bus0.fin);
      end
      checks++;
      if (bus1.fila !== 4'b0000 || bus1.ocupado !== 1'b0 || bus1.contacto !== 1'b0 || bus1.fin !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle1 fila %b ocupado %b contacto %b fin %b exp 0000 0 0 0",
                 bus1.fila, bus1.ocupado, bus1.contacto, bus1.fin);
      end
    end
  endtask

  task automatic test_press_bounce();
    logic ec;
    logic [3:0] ef;
    bus0.tecla = 4'b0110;
    bus0.inicio = 1'b1;
    tick();
    bus0.inicio = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      bus0.tecla = 4'($urandom_range(0, 15));
      bus0.col = (k % 3 == 0) ? 4'($urandom_range(0, 15)) : (4'b0001 << (k % 4));
      #1;
      ec = (k <= 4) ? ((k % 2) == 1) : (k <= 12);
      ef = (ec && bus0.col[2]) ? 4'b0010 : 4'b0000;
      checks++;
      if (bus0.contacto !== ec) begin
        errors++;
        $display("FAIL press_contacto k=%0d got %b exp %b", k, bus0.contacto, ec);
      end
      checks++;
      if (bus0.fila !== ef) begin
        errors++;
        $display("FAIL press_fila k=%0d col %b got %b exp %b", k, bus0.col, bus0.fila, ef);
      end
      checks++;
      if (bus0.fin !== (k == 17) || bus0.ocupado !== (k <= 16)) begin
        errors++;
        $display("FAIL press_fin k=%0d fin %b ocupado %b exp %b %b", k, bus0.fin, bus0.ocupado, k == 17, k <= 16);
      end
      tick();
    end
  endtask

  task automatic test_no_bounce();
    logic ec;
    logic [3:0] ef;
    bus1.tecla = 4'b1111;
    bus1.inicio = 1'b1;
    tick();
    bus1.inicio = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      bus1.col = (k % 2 == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
      #1;
      ec = (k <= 8);
      ef = (ec && bus1.col[3]) ? 4'b1000 : 4'b0000;
      checks++;
      if (bus1.contacto !== ec || bus1.fila !== ef) begin
        errors++;
        $display("FAIL nobounce k=%0d contacto %b fila %b exp %b %b", k, bus1.contacto, bus1.fila, ec, ef);
      end
      checks++;
      if (bus1.fin !== (k == 13)) begin
        errors++;
        $display("FAIL nobounce_fin k=%0d got %b exp %b", k, bus1.fin, k == 13);
      end
      tick();
    end
  endtask

  task automatic test_ignore_busy();
    logic ec;
    bus0.tecla = 4'b0110;
    bus0.inicio = 1'b1;
    tick();
    for (int k = 1; k <= 17; k++) begin
      bus0.col = 4'b0100;
      bus0.inicio = (k == 5) || (k == 17);
      bus0.tecla = bus0.inicio ? 4'b1001 : 4'($urandom_range(0, 15));
      #1;
      ec = (k <= 4) ? ((k % 2) == 1) : (k <= 12);
      checks++;
      if (bus0.fila !== (ec ? 4'b0010 : 4'b0000) || bus0.ocupado !== (k <= 16) || bus0.fin !== (k == 17)) begin
        errors++;
        $display("FAIL ignore k=%0d fila %b ocupado %b fin %b exp %b %b %b", k, bus0.fila, bus0.ocupado,
                 bus0.fin, ec ? 4'b0010 : 4'b0000, k <= 16, k == 17);
      end
      tick();
    end
    bus0.inicio = 1'b0;
    bus0.col = 4'b0010;
    #1;
    checks++;
    if (bus0.ocupado !== 1'b1 || bus0.contacto !== 1'b1 || bus0.fila !== 4'b0100) begin
      errors++;
      $display("FAIL accept_on_fin ocupado %b contacto %b fila %b exp 1 1 0100",
               bus0.ocupado, bus0.contacto, bus0.fila);
    end
    repeat (20) tick();
  endtask

  task automatic test_reset_mid();
    bus0.tecla = 4'($urandom_range(0, 15));
    bus0.inicio = 1'b1;
    tick();
    bus0.inicio = 1'b0;
    for (int k = 1; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus0.col = 4'b1111;
    #1;
    checks++;
    if (bus0.fila !== 4'b0000 || bus0.ocupado !== 1'b0 || bus0.contacto !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid fila %b ocupado %b contacto %b exp 0000 0 0", bus0.fila, bus0.ocupado, bus0.contacto);
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      checks++;
      if (bus0.fin !== 1'b0 || bus0.ocupado !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_nofin k=%0d fin %b ocupado %b exp 0 0", k, bus0.fin, bus0.ocupado);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus0.inicio = ($urandom_range(0, 3) == 0);
      bus1.inicio = ($urandom_range(0, 3) == 0);
      bus0.tecla = 4'($urandom_range(0, 15));
      bus1.tecla = 4'($urandom_range(0, 15));
      bus0.col = 4'($urandom_range(0, 15));
      bus1.col = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (bus0.contacto !== exp_contacto(0) || bus0.ocupado !== (ph[0] != 0) || bus0.fin !== fin_e[0]) begin
        errors++;
        $display("FAIL random0 n=%0d contacto %b ocupado %b fin %b exp %b %b %b", n, bus0.contacto,
                 bus0.ocupado, bus0.fin, exp_contacto(0), ph[0] != 0, fin_e[0]);
      end
      checks++;
      if (bus0.fila !== exp_fila(0, bus0.col)) begin
        errors++;
        $display("FAIL random0_fila n=%0d col %b got %b exp %b", n, bus0.col, bus0.fila, exp_fila(0, bus0.col));
      end
      checks++;
      if (bus1.contacto !== exp_contacto(1) || bus1.ocupado !== (ph[1] != 0) || bus1.fin !== fin_e[1]) begin
        errors++;
        $display("FAIL random1 n=%0d contacto %b ocupado %b fin %b exp %b %b %b", n, bus1.contacto,
                 bus1.ocupado, bus1.fin, exp_contacto(1), ph[1] != 0, fin_e[1]);
      end
      checks++;
      if (bus1.fila !== exp_fila(1, bus1.col)) begin
        errors++;
        $display("FAIL random1_fila n=%0d col %b got %b exp %b", n, bus1.col, bus1.fila, exp_fila(1, bus1.col));
      end
      tick();
    end
    rst = 1'b0;
    bus0.inicio = 1'b0;
    bus1.inicio = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; key[i] = 4'b0000; fin_e[i] = 1'b0;
    end
    rst = 1'b1;
    bus0.inicio = 1'b0; bus1.inicio = 1'b0;
    bus0.tecla = 4'b0000; bus1.tecla = 4'b0000;
    bus0.col = 4'b0000; bus1.col = 4'b0000;
    test_reset();
    test_press_bounce();
    test_no_bounce();
    test_ignore_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/emulador_teclado.md
# emulador_teclado

Matrix-keypad emulator: the passive key-matrix end of the scanning interface that `Driver_teclado` drives. It accepts a key-press command and presents a bouncing, then stable, then released contact between one column line and one row line. The row lines respond combinationally to the column scan, exactly as a real keypad does. It sits opposite `Driver_teclado` in system benches and hardware self-test, so that driver can be exercised without a physical keypad.

## Interface
- `col_1`..`col_4`, defaults 4'b0001/0010/0100/1000, column line codes (same values `Driver_teclado` uses)
- `fila_1`..`fila_4`, defaults 4'b0001/0010/0100/1000, row line codes
- `REBOTE_CICLOS`, 4, bounce phase length in clk cycles (0 = no bounce)
- `HOLD_CICLOS`, 8, stable-closed phase length in cycles (≥1)
- `GAP_CICLOS`, 4, released phase before completion (≥1)
- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `col`  in  4  column scan from the driver
- `fila`  out  4  row lines back to the driver
- `tecla`  in  4  key to press: [3:2] row index 0..3, [1:0] column index 0..3
- `inicio`  in  1  start command, sampled when `ocupado`=0
- `ocupado`  out  1  command in progress
- `contacto`  out  1  current emulated contact state (closed=1)
- `fin`  out  1  one-cycle pulse when a press/release sequence completes

## Operation
- Reset values: state IDLE, `ocupado`=0, `contacto`=0, `fin`=0, `fila`=0, counters 0, latched key 0.
- States: IDLE → REBOTE → FIRME → SUELTA → IDLE.
- IDLE: if `inicio`=1, latch `tecla`. Next state is REBOTE, or FIRME when `REBOTE_CICLOS`=0. Load the phase counter.
- REBOTE: `contacto` toggles every cycle, starting at 1. Lasts exactly `REBOTE_CICLOS` cycles, then goes to FIRME.
- FIRME: `contacto`=1 for exactly `HOLD_CICLOS` cycles, then goes to SUELTA.
- SUELTA: `contacto`=0 for exactly `GAP_CICLOS` cycles, then goes to IDLE with `fin`=1 on the first IDLE cycle.
- `ocupado`=1 in every non-IDLE state.
- `inicio` while `ocupado`=1 is ignored; no queuing.
- `inicio` on the same cycle `fin`=1 is accepted, because the state is IDLE.
- `tecla` changes after latching have no effect until the next accepted command.
- `fila` is combinational: `fila = fila_r` when `contacto`=1 and `(col & col_c)`≠0, else 4'b0000. Here `fila_r` and `col_c` are the codes for the latched row and column indices.
- Multiple active column bits: respond if the latched column's bit is among them.
- Phase counter width is `$clog2` of the largest phase parameter plus 1. The counter counts down; the phase ends when it reaches 1.

## Timing
- Command accepted at edge N (`inicio`=1, IDLE).
- `ocupado`=1 and `contacto`=1 from cycle N+1.
- With defaults:
  - bounce on cycles N+1..N+4 (`contacto` 1,0,1,0)
  - closed N+5..N+12
  - open N+13..N+16
  - `fin`=1 on N+17
- Total busy cycles = `REBOTE_CICLOS + HOLD_CICLOS + GAP_CICLOS`.
- `col`→`fila`: zero-cycle combinational path. No registers between `col` and `fila`.
- `rst` mid-sequence: the next cycle is IDLE, `contacto`=0, `fila`=0, and no `fin` pulse.
- `rst` and `inicio` asserted together: reset wins.

## Structure
- Shared package holds the row/column code constants and the state encoding (IDLE, REBOTE, FIRME, SUELTA). `Driver_teclado` and the emulator import the same codes.
- Single module. A sub-module `mapa_tecla` (index pair → `col_c`/`fila_r` one-hot codes, purely combinational) is natural and reusable by the driver's decoder check.

## Test plan
- Reset, then `col`=4'b1111 with no command → `fila`=0, `ocupado`=0, `contacto`=0 throughout.
- `tecla`=4'b0110 (row 1, col 2), defaults, driver scanning:
  - `fila`=4'b0010 only while `col`=4'b0100 and `contacto`=1
  - `contacto` pattern 1,0,1,0 then 8×1 then 4×0
  - `fin` on cycle N+17
- `REBOTE_CICLOS`=0, `tecla`=4'b1111 → `contacto`=1 from N+1 for 8 cycles; `fila`=4'b1000 when `col`=4'b1000; `fin` at N+13.
- `inicio` pulsed again at N+5 with a different `tecla` → ignored; the original key completes unchanged; a new `inicio` on the `fin` cycle is accepted.
- `rst` asserted at N+7 (in FIRME) → next cycle `fila`=0, `ocupado`=0, no `fin` pulse.
- Full loop with `Driver_teclado`: press keys (0,0), (1,1), (2,2) in sequence → one `cambio_digito` pulse per key with the matching `digito` value, and no pulses during bounce.
